cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 118 +++++++++++
 tb/tb_cache_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// Latches the winner's address, write line and command type at grant; one transaction at a time.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no transaction outstanding; arbitrate pending requests
// SERVE_I | I-cache line fill in flight, waiting for pmem_resp
// SERVE_D | D-cache fill or writeback in flight, waiting for pmem_resp
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,

    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                  state, state_next;
    logic                    last_grant, last_grant_next;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_next;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_next;
    logic                    d_write_q, d_write_next;

    logic                    i_req;
    logic                    d_req;
    logic                    grant_d;

    assign i_req   = icache_read;
    assign d_req   = dcache_read | dcache_write;
    // On a tie, the side that did not win last time goes next.
    assign grant_d = d_req & (~i_req | (last_grant == GRANT_I));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            d_write_q  <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            addr_q     <= addr_next;
            wdata_q    <= wdata_next;
            d_write_q  <= d_write_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        addr_next       = addr_q;
        wdata_next      = wdata_q;
        d_write_next    = d_write_q;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next      = SERVE_D;
                    last_grant_next = GRANT_D;
                    addr_next       = dcache_address;
                    wdata_next      = dcache_wdata;
                    // A simultaneous read+write resolves to the writeback.
                    d_write_next    = dcache_write;
                end else if (i_req) begin
                    state_next      = SERVE_I;
                    last_grant_next = GRANT_I;
                    addr_next       = icache_address;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pmem_read    = (state == SERVE_I) | ((state == SERVE_D) & ~d_write_q);
    assign pmem_write   = (state == SERVE_D) & d_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Reset wins over a same-cycle pmem_resp: the abandoned transaction never completes.
    assign icache_resp  = (state == SERVE_I) & pmem_resp & ~rst;
    assign dcache_resp  = (state == SERVE_D) & pmem_resp & ~rst;

    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a transaction-level round-robin model predicts grant
// order and latched contents; a monitor checks every pmem transaction and resp pulse.
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_read;
    logic [AW-1:0] icache_address;
    logic [LW-1:0] icache_rdata;
    logic          icache_resp;
    logic          dcache_read;
    logic          dcache_write;
    logic [AW-1:0] dcache_address;
    logic [LW-1:0] dcache_wdata;
    logic [LW-1:0] dcache_rdata;
    logic          dcache_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            side_d;
        logic [AW-1:0] addr;
        bit            wr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   model_last_d = 1'b0;   // side granted most recently, 1 = D

    bit   mem_en     = 1'b1;
    bit   force_resp = 1'b0;
    int   fixed_lat  = -1;

    task automatic check(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory responder: random latency after seeing a command, one-cycle pmem_resp pulse.
    int wait_cnt = -1;
    always begin
        @(posedge clk);
        #1;
        if (!mem_en) begin
            pmem_resp = force_resp;
            wait_cnt  = -1;
        end else if (pmem_resp) begin
            pmem_resp = 1'b0;
        end else if (pmem_read || pmem_write) begin
            if (wait_cnt < 0) wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            if (wait_cnt == 0) begin
                pmem_rdata = rand_line();
                pmem_resp  = 1'b1;
                wait_cnt   = -1;
            end else begin
                wait_cnt--;
            end
        end
    end

    // Monitor: pops the expected transaction at each command start, checks it for the whole service.
    bit   active   = 1'b0;
    bit   cmd_prev = 1'b0;
    txn_t cur;
    always @(negedge clk) begin
        bit cmd;
        cmd = pmem_read | pmem_write;
        check("cmd_exclusive", LW'(pmem_read & pmem_write), LW'(0));
        if (rst) begin
            check("resp_in_reset", LW'({icache_resp, dcache_resp}), LW'(0));
            active = 1'b0;
        end else begin
            if (cmd && !cmd_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", LW'(1), LW'(0));
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                end
            end
            if (active && cmd) begin
                check("pmem_address", LW'(pmem_address), LW'(cur.addr));
                check("pmem_type", LW'({pmem_write, pmem_read}), LW'(cur.wr ? 2'b10 : 2'b01));
                if (cur.wr) check("pmem_wdata", pmem_wdata, cur.wdata);
            end
            if (pmem_resp && active) begin
                check("resp_sides", LW'({icache_resp, dcache_resp}),
                      LW'(cur.side_d ? 2'b01 : 2'b10));
                check(cur.side_d ? "dcache_rdata" : "icache_rdata",
                      cur.side_d ? dcache_rdata : icache_rdata, pmem_rdata);
                active = 1'b0;
            end else if (icache_resp || dcache_resp) begin
                check("stray_resp", LW'({icache_resp, dcache_resp}), LW'(0));
            end
        end
        cmd_prev = cmd;
    end

    task automatic idle_inputs();
        icache_read  = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
    endtask

    // d_kind: 0 read, 1 write, 2 read+write (served as write).
    task automatic run_round(bit want_i, bit want_d, int d_kind,
                             logic [AW-1:0] ia, logic [AW-1:0] da, bit drop_first);
        txn_t ti, td;
        bit   first_d, i_done, d_done;
        int   k;
        ti = '{side_d: 1'b0, addr: ia, wr: 1'b0, wdata: '0};
        td = '{side_d: 1'b1, addr: da, wr: (d_kind != 0), wdata: rand_line()};
        first_d = want_d && (!want_i || !model_last_d);
        if (want_i && want_d) begin
            if (first_d) begin exp_q.push_back(td); exp_q.push_back(ti); model_last_d = 1'b0; end
            else begin exp_q.push_back(ti); exp_q.push_back(td); model_last_d = 1'b1; end
        end else if (want_d) begin
            exp_q.push_back(td); model_last_d = 1'b1;
        end else begin
            exp_q.push_back(ti); model_last_d = 1'b0;
        end

        @(posedge clk);
        #1;
        icache_read    = want_i;
        icache_address = ia;
        dcache_read    = want_d && (d_kind != 1);
        dcache_write   = want_d && (d_kind != 0);
        dcache_address = da;
        dcache_wdata   = td.wdata;
        i_done = !want_i;
        d_done = !want_d;
        k = 0;
        while (!(i_done && d_done) && k < 80) begin
            @(posedge clk);
            #2;
            k++;
            if (k == 1) check("cmd_latency", LW'(pmem_read | pmem_write), LW'(1));
            if (first_d && !d_done) begin
                dcache_address = $urandom;
                dcache_wdata   = rand_line();
                if (drop_first) begin dcache_read = 1'b0; dcache_write = 1'b0; end
            end
            if (!first_d && !i_done) begin
                icache_address = $urandom;
                if (drop_first) icache_read = 1'b0;
            end
            if (icache_resp) begin icache_read = 1'b0; i_done = 1'b1; end
            if (dcache_resp) begin dcache_read = 1'b0; dcache_write = 1'b0; d_done = 1'b1; end
        end
        if (!(i_done && d_done)) begin
            check("round_timeout", LW'({i_done, d_done}), LW'(2'b11));
            idle_inputs();
        end
    endtask

    initial begin
        rst            = 1'b1;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
        icache_address = '0;
        dcache_address = '0;
        dcache_wdata   = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_cmds", LW'({pmem_read, pmem_write, icache_resp, dcache_resp}), LW'(0));
        check("reset_addr", LW'(pmem_address), LW'(0));
        check("reset_wdata", pmem_wdata, '0);

        // Lone I fill at 0x1000 with memory latency 5.
        fixed_lat = 4;
        run_round(1'b1, 1'b0, 0, 32'h0000_1000, 32'h0, 1'b0);
        fixed_lat = -1;

        // Tie after reset is D-first; two ties in a row both go to D.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_last_d = 1'b0;
        run_round(1'b1, 1'b1, 1, 32'h0000_2000, 32'h0000_3000, 1'b0);
        run_round(1'b1, 1'b1, 1, 32'h0000_4000, 32'h0000_5000, 1'b0);

        // Continuous contention: grants must alternate.
        for (int r = 0; r < 5; r++)
            run_round(1'b1, 1'b1, int'($urandom_range(0, 2)), $urandom, $urandom, 1'b0);

        // Spurious pmem_resp while idle.
        mem_en = 1'b0;
        @(posedge clk);
        #2 force_resp = 1'b1;
        @(posedge clk);
        #3 force_resp = 1'b0;
        @(posedge clk);
        #2;
        check("spurious_no_cmd", LW'({pmem_read, pmem_write, icache_resp, dcache_resp}), LW'(0));

        // Reset during SERVE_I together with pmem_resp: abandoned, no icache_resp.
        exp_q.push_back('{side_d: 1'b0, addr: 32'h0000_7000, wr: 1'b0, wdata: '0});
        @(posedge clk);
        #1;
        icache_read    = 1'b1;
        icache_address = 32'h0000_7000;
        @(posedge clk);
        #2;
        check("rst_test_grant", LW'(pmem_read), LW'(1));
        force_resp = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b1;
        icache_read = 1'b0;
        #1;
        check("rst_vs_resp", LW'(icache_resp), LW'(0));
        #1 force_resp = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_last_d = 1'b0;
        check("post_rst_outputs", LW'({pmem_read, pmem_write, icache_resp, dcache_resp}), LW'(0));
        check("post_rst_addr", LW'(pmem_address), LW'(0));
        mem_en = 1'b1;

        // Randomized traffic, including dropped requests and read+write collisions.
        for (int r = 0; r < 40; r++) begin
            int want;
            want = int'($urandom_range(1, 3));
            run_round(want[0], want[1], int'($urandom_range(0, 2)),
                      $urandom & 32'hffff_ffe0, $urandom & 32'hffff_ffe0,
                      ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", LW'(exp_q.size()), LW'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
